// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier: WIDTH x WIDTH -> 2*WIDTH, signed or unsigned per request.
// One add/sub-and-shift iteration per clock, WIDTH+1 iterations per product, start/busy/done handshake.
module booth_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               done
);

    localparam int N  = WIDTH + 1;       // iterations; operands carry one extra sign bit
    localparam int AW = WIDTH + 2;       // accumulator with one guard bit
    localparam int TW = AW + N + 1;      // full {acc, q, q_m1} shift register
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                     state;
    logic signed [AW-1:0]       acc;
    logic        [WIDTH:0]      q;
    logic                       q_m1;
    logic signed [WIDTH:0]      m;
    logic        [CW-1:0]       cnt;

    logic signed [AW-1:0]       acc_sum;
    logic signed [TW-1:0]       step;
    logic signed [AW-1:0]       step_acc;
    logic        [WIDTH:0]      step_q;
    logic                       step_qm1;

    // Unsigned operands get a zero top bit so the Booth recoding treats them as positive.
    function automatic logic signed [WIDTH:0] extend(input logic [WIDTH-1:0] v,
                                                     input logic             sgn);
        return {sgn & v[WIDTH-1], v};
    endfunction

    function automatic logic signed [AW-1:0] booth_add(input logic signed [AW-1:0] acc_in,
                                                       input logic signed [WIDTH:0] mcand,
                                                       input logic        [1:0]     pair);
        logic signed [AW-1:0] mx;
        mx = {mcand[WIDTH], mcand};
        case (pair)
            2'b01:   return acc_in + mx;
            2'b10:   return acc_in - mx;
            default: return acc_in;
        endcase
    endfunction

    function automatic logic signed [TW-1:0] booth_shift(input logic signed [TW-1:0] v);
        return v >>> 1;
    endfunction

    // Add and shift happen on the same edge: the shift sees the fresh sum.
    always_comb begin
        acc_sum  = booth_add(acc, m, {q[0], q_m1});
        step     = booth_shift({acc_sum, q, q_m1});
        step_acc = step[TW-1 -: AW];
        step_q   = step[N:1];
        step_qm1 = step[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            acc     <= '0;
            q       <= '0;
            q_m1    <= 1'b0;
            m       <= '0;
            cnt     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        m     <= extend(a, signed_op);
                        q     <= extend(b, signed_op);
                        q_m1  <= 1'b0;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc  <= step_acc;
                    q    <= step_q;
                    q_m1 <= step_qm1;
                    cnt  <= cnt + 1'b1;
                    // Low 2*WIDTH bits of {acc, q} after the last shift are exact in both modes.
                    if (cnt == LAST) begin
                        product <= step[2*WIDTH:1];
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq: three instances (WIDTH 4, 8, 16) share stimulus and are checked
// against an integer-arithmetic product model, plus directed handshake/reset/corner cases.
module tb_booth_mult_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sop;
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  p4;
    logic [15:0] p8;
    logic [31:0] p16;
    logic        busy4, busy8, busy16;
    logic        done4, done8, done16;

    int checks   = 0;
    int failures = 0;
    logic [31:0] res8;

    always #5 clk = ~clk;

    booth_mult_seq #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .start(start), .signed_op(sop), .a(a[3:0]), .b(b[3:0]),
        .product(p4), .busy(busy4), .done(done4)
    );
    booth_mult_seq #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start), .signed_op(sop), .a(a[7:0]), .b(b[7:0]),
        .product(p8), .busy(busy8), .done(done8)
    );
    booth_mult_seq #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .start(start), .signed_op(sop), .a(a), .b(b),
        .product(p16), .busy(busy16), .done(done16)
    );

    // Exact product of the low w bits of x and y, interpreted per mode, truncated to 2*w bits.
    function automatic logic [31:0] model(input int w, input logic [15:0] x,
                                          input logic [15:0] y, input logic s);
        longint xv, yv, pr, mask;
        mask = (longint'(1) << w) - 1;
        xv = longint'(x) & mask;
        yv = longint'(y) & mask;
        if (s) begin
            if (xv >= (longint'(1) << (w - 1))) xv = xv - (longint'(1) << w);
            if (yv >= (longint'(1) << (w - 1))) yv = yv - (longint'(1) << w);
        end
        pr = xv * yv;
        return 32'(pr & ((longint'(1) << (2 * w)) - 1));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && (busy4 || busy8 || busy16); i++) begin
            @(posedge clk); #1;
        end
        check("idle_wait", 32'({busy4, busy8, busy16}), 32'd0);
    endtask

    // Launch one operation on all three instances and watch 20 cycles past the start edge.
    task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic s);
        int lat4, lat8, lat16, bz4, bz8, bz16, dn4, dn8, dn16;
        logic [31:0] r4, r8, r16;
        wait_idle();
        lat4 = -1; lat8 = -1; lat16 = -1;
        bz4 = 0; bz8 = 0; bz16 = 0; dn4 = 0; dn8 = 0; dn16 = 0;
        r4 = 'x; r8 = 'x; r16 = 'x;
        a = x; b = y; sop = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c <= 20; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            if (busy4)  bz4++;
            if (busy8)  bz8++;
            if (busy16) bz16++;
            if (done4)  begin dn4++;  if (lat4 < 0)  begin lat4 = c;  r4 = 32'(p4);  end end
            if (done8)  begin dn8++;  if (lat8 < 0)  begin lat8 = c;  r8 = 32'(p8);  end end
            if (done16) begin dn16++; if (lat16 < 0) begin lat16 = c; r16 = 32'(p16); end end
        end
        check("prod_w4",  r4,  model(4, x, y, s));
        check("prod_w8",  r8,  model(8, x, y, s));
        check("prod_w16", r16, model(16, x, y, s));
        check("lat_w4",  32'(lat4),  32'd5);
        check("lat_w8",  32'(lat8),  32'd9);
        check("lat_w16", 32'(lat16), 32'd17);
        check("busy_cycles_w4",  32'(bz4),  32'd5);
        check("busy_cycles_w8",  32'(bz8),  32'd9);
        check("busy_cycles_w16", 32'(bz16), 32'd17);
        check("done_pulses_w4",  32'(dn4),  32'd1);
        check("done_pulses_w8",  32'(dn8),  32'd1);
        check("done_pulses_w16", 32'(dn16), 32'd1);
        res8 = r8;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int dn;
        logic [31:0] held;

        rst = 1'b1; start = 1'b0; sop = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_product", {16'(p4), p8} | p16, 32'd0);
        check("reset_busy", 32'({busy4, busy8, busy16}), 32'd0);
        check("reset_done", 32'({done4, done8, done16}), 32'd0);

        // Signed and unsigned corners at WIDTH 8
        run_op(16'h0080, 16'h0080, 1'b1); check("min_x_min",   res8, 32'h4000);
        run_op(16'h0080, 16'h007F, 1'b1); check("min_x_max",   res8, 32'hC080);
        run_op(16'h00FF, 16'h0001, 1'b1); check("neg1_x_1",    res8, 32'hFFFF);
        run_op(16'h00FF, 16'h00FF, 1'b0); check("u255_x_255",  res8, 32'hFE01);
        run_op(16'h00FF, 16'h00FF, 1'b1); check("s_m1_x_m1",   res8, 32'h0001);
        run_op(16'h0000, 16'h00C8, 1'b0); check("zero_x_200",  res8, 32'h0000);

        // start held through RUN with operands changing every cycle
        wait_idle();
        a = 16'd3; b = 16'd7; sop = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        lat = -1; dn = 0; held = 'x;
        for (int c = 1; c <= 12; c++) begin
            if (c <= 8) begin
                a = 16'($urandom); b = 16'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done8) begin
                dn++;
                if (lat < 0) begin lat = c; held = 32'(p8); end
            end
        end
        check("held_start_prod", held, 32'h0015);
        check("held_start_lat", 32'(lat), 32'd9);
        check("held_start_pulses", 32'(dn), 32'd1);
        check("held_start_idle", 32'(busy8), 32'd0);

        // Back-to-back: second start in the done cycle
        wait_idle();
        a = 16'd5; b = 16'd6; sop = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 12 && lat < 0; c++) begin
            @(posedge clk); #1;
            if (done8) lat = c;
        end
        check("b2b_first_lat", 32'(lat), 32'd9);
        check("b2b_first_prod", 32'(p8), 32'h001E);
        a = 16'h00FD; b = 16'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_done_drop", 32'(done8), 32'd0);
        check("b2b_busy_rise", 32'(busy8), 32'd1);
        check("b2b_prod_held", 32'(p8), 32'h001E);
        lat = -1;
        for (int c = 1; c <= 12 && lat < 0; c++) begin
            @(posedge clk); #1;
            if (done8) lat = c;
        end
        check("b2b_second_lat", 32'(lat), 32'd9);
        check("b2b_second_prod", 32'(p8), 32'hFFEB);

        // Reset during iteration 4 aborts the operation
        wait_idle();
        a = 16'h0012; b = 16'h0034; sop = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("pre_reset_busy", 32'(busy8), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", 32'(busy8), 32'd0);
        check("abort_done", 32'(done8), 32'd0);
        check("abort_product", 32'(p8), 32'd0);
        run_op(16'd3, 16'd5, 1'b1); check("after_reset_3x5", res8, 32'h000F);

        // Idle hold after completion
        held = 32'(p8);
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            check("idle_product", 32'(p8), held);
            check("idle_busy", 32'(busy8), 32'd0);
            check("idle_done", 32'(done8), 32'd0);
        end

        // Exhaustive WIDTH 4, both modes
        for (int s = 0; s < 2; s++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++)
                    run_op(16'(x), 16'(y), 1'(s));

        // Random operands and modes
        for (int i = 0; i < 1500; i++)
            run_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
